ld_st_control_unit: RTL

Moore control FSM that sequences the bus-based CPU datapath through instruction fetch and execution of `ld`, `ldi`, `st`, `add`, `sub`, `addi`, `nop` and `halt`. It drives every datapath strobe for one full clock cycle per control step (T0–T7). It waits on a memory-ready handshake during every memory access. It sits beside the `datapath` instance and replaces the hand-scripted strobe sequences used in standalone datapath benches.

---
 rtl/ld_st_control_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ld_st_control_unit.sv
// ld_st_control_unit
// Moore control FSM for the bus-based CPU datapath. It sequences instruction
// fetch (T0-T2) and the execute steps (T3-T7) of ld, ldi, st, add, sub, addi,
// nop and halt. It holds every datapath strobe for one full clock per step.
//
// Ports
//   clk      : system clock, rising edge
//   clr      : synchronous active-high reset (to RST)
//   ir       : IR contents from the datapath, opcode in ir[31:27]
//   mem_rdy  : memory finished the current Read/Write this cycle
//   run      : 1 while executing, 0 once halted
//   PCout..BAout           : bus drivers
//   MARin..Rin             : register loads
//   Gra/Grb/Grc            : GPR field select
//   IncPC/ADD/SUB          : ALU operation
//   Read/Write             : memory requests
module ld_st_control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        mem_rdy,
  output logic        run,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Rout,
  output logic        Cout,
  output logic        BAout,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        PCin,
  output logic        Rin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        IncPC,
  output logic        ADD,
  output logic        SUB,
  output logic        Read,
  output logic        Write
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     state_q, state_d;
  logic [4:0] op_q, op_d;
  logic [4:0] op_cur;
  logic       is_ld, is_ldi, is_st, is_add, is_sub, is_addi, is_halt;
  logic       addr_form, reg_form;

  // NOTE: state flops use non-blocking assignments and a synchronous clr,
  // so every register updates together on the edge and reset has no async path.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_RST;
      op_q    <= OP_NOP;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // In T3 the opcode comes straight from IR (loaded at the end of T2); it is
  // latched on the T3 edge so later steps ignore any change on ir.
  always_comb begin
    op_cur    = (state_q == S_T3) ? ir[31:27] : op_q;
    op_d      = (state_q == S_T3) ? ir[31:27] : op_q;
    is_ld     = (op_cur == OP_LD);
    is_ldi    = (op_cur == OP_LDI);
    is_st     = (op_cur == OP_ST);
    is_add    = (op_cur == OP_ADD);
    is_sub    = (op_cur == OP_SUB);
    is_addi   = (op_cur == OP_ADDI);
    is_halt   = (op_cur == OP_HALT);
    addr_form = is_ld | is_ldi | is_st;   // effective address = rb/0 + C
    reg_form  = is_add | is_sub | is_addi;
  end

  // NOTE: every output and state_d gets a default first, so no path through
  // this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    run     = 1'b1;
    PCout   = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; Rout  = 1'b0;
    Cout    = 1'b0; BAout   = 1'b0; MARin  = 1'b0; MDRin = 1'b0;
    IRin    = 1'b0; Yin     = 1'b0; Zin    = 1'b0; PCin  = 1'b0;
    Rin     = 1'b0; Gra     = 1'b0; Grb    = 1'b0; Grc   = 1'b0;
    IncPC   = 1'b0; ADD     = 1'b0; SUB    = 1'b0;
    Read    = 1'b0; Write   = 1'b0;

    unique case (state_q)
      S_RST: state_d = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        if (mem_rdy) state_d = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        if (addr_form) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (reg_form) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end
        if (is_halt)                     state_d = S_HALT;
        else if (addr_form || reg_form)  state_d = S_T4;
        else                             state_d = S_T0;  // nop and unknown
      end
      S_T4: begin
        Zin = 1'b1;
        if (is_add || is_sub) begin
          Grc = 1'b1; Rout = 1'b1; ADD = is_add; SUB = is_sub;
        end else begin
          Cout = 1'b1; ADD = 1'b1;
        end
        state_d = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_ld || is_st) begin
          MARin   = 1'b1;
          state_d = S_T6;
        end else begin
          Gra = 1'b1; Rin = 1'b1;
          state_d = S_T0;
        end
      end
      S_T6: begin
        MDRin = 1'b1;
        if (is_st) begin
          Gra = 1'b1; Rout = 1'b1;
          state_d = S_T7;
        end else begin
          Read = 1'b1;
          if (mem_rdy) state_d = S_T7;
        end
      end
      S_T7: begin
        if (is_st) begin
          Write = 1'b1;
          if (mem_rdy) state_d = S_T0;
        end else begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          state_d = S_T0;
        end
      end
      S_HALT: run = 1'b0;
      default: state_d = S_RST;
    endcase
  end

endmodule
